// File: rtl/frame_seq_pkg.sv
// Shared types and default constants for the triple-buffer frame sequencer.
// Holds the buffer-index type, the per-side FSM state encoding and parameter defaults.
package frame_seq_pkg;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic [1:0] {
        SIDE_IDLE   = 2'd0,
        SIDE_LOAD   = 2'd1,
        SIDE_ACTIVE = 2'd2
    } side_state_t;

    localparam int unsigned DEF_ASIZE       = 23;
    localparam int unsigned DEF_FRAME_WORDS = 307200;
    localparam logic [22:0] DEF_BUF_STRIDE  = 23'h080000;
    localparam int unsigned DEF_LOAD_CYCLES = 4;

endpackage

// File: rtl/frame_buffer_sequencer_if.sv
// Frame-start strobes in, SDRAM controller address/load controls and status out.
// master: frame timing source / observer side; slave: the sequencer.
interface frame_buffer_sequencer_if #(
    parameter int unsigned ASIZE = 23
);
    logic             WR_VS;
    logic             RD_VS;
    logic [ASIZE-1:0] WR_ADDR;
    logic [ASIZE-1:0] WR_MAX_ADDR;
    logic             WR_LOAD;
    logic [ASIZE-1:0] RD_ADDR;
    logic [ASIZE-1:0] RD_MAX_ADDR;
    logic             RD_LOAD;
    logic [1:0]       WR_BUF;
    logic [1:0]       RD_BUF;
    logic             FRAME_VALID;
    logic [7:0]       DROP_CNT;

    modport master (
        output WR_VS, RD_VS,
        input  WR_ADDR, WR_MAX_ADDR, WR_LOAD, RD_ADDR, RD_MAX_ADDR, RD_LOAD,
        input  WR_BUF, RD_BUF, FRAME_VALID, DROP_CNT
    );

    modport slave (
        input  WR_VS, RD_VS,
        output WR_ADDR, WR_MAX_ADDR, WR_LOAD, RD_ADDR, RD_MAX_ADDR, RD_LOAD,
        output WR_BUF, RD_BUF, FRAME_VALID, DROP_CNT
    );
endinterface

// File: rtl/frame_seq_side.sv
// One port's IDLE/LOAD/ACTIVE sequencer: an accepted VS starts a LOAD_CYCLES-long
// load pulse; a VS during the pulse restarts it.
module frame_seq_side
    import frame_seq_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES = DEF_LOAD_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs,
    input  logic        en,
    output side_state_t state,
    output logic        load
);

    localparam logic [3:0] CNT_INIT = 4'(LOAD_CYCLES - 1);

    side_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        load_q, load_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        case (state_q)
            SIDE_IDLE, SIDE_ACTIVE: begin
                if (vs && en) begin
                    state_d = SIDE_LOAD;
                    cnt_d   = CNT_INIT;
                    load_d  = 1'b1;
                end
            end
            SIDE_LOAD: begin
                if (vs && en) begin
                    cnt_d = CNT_INIT;
                end else if (cnt_q == '0) begin
                    state_d = SIDE_ACTIVE;
                    load_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = SIDE_IDLE;
                load_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SIDE_IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    assign state = state_q;
    assign load  = load_q;

endmodule

// File: rtl/frame_buffer_sequencer.sv
// Triple-buffer sequencer: rotates WR/RD/LATEST buffer indices on frame starts and
// presents registered SDRAM address windows plus load pulses for each side.
module frame_buffer_sequencer
    import frame_seq_pkg::*;
#(
    parameter int unsigned      ASIZE       = DEF_ASIZE,
    parameter int unsigned      FRAME_WORDS = DEF_FRAME_WORDS,
    parameter logic [ASIZE-1:0] BUF_STRIDE  = ASIZE'(DEF_BUF_STRIDE),
    parameter int unsigned      LOAD_CYCLES = DEF_LOAD_CYCLES
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    frame_buffer_sequencer_if.slave   bus
);

    localparam logic [ASIZE-1:0] FRAME_LEN    = ASIZE'(FRAME_WORDS);
    localparam logic [ASIZE-1:0] RD_ADDR_RST  = BUF_STRIDE << 1;

    function automatic logic [ASIZE-1:0] buf_addr(input buf_idx_t idx);
        return ASIZE'(idx) * BUF_STRIDE;
    endfunction

    side_state_t wr_state, rd_state;
    logic        wr_load, rd_load;

    buf_idx_t         wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d, latest_q, latest_d;
    logic             fresh_q, fresh_d, frame_valid_q, frame_valid_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [ASIZE-1:0] wr_addr_q, wr_addr_d, wr_max_q, wr_max_d;
    logic [ASIZE-1:0] rd_addr_q, rd_addr_d, rd_max_q, rd_max_d;
    logic             wr_done, rd_take;

    frame_seq_side #(.LOAD_CYCLES(LOAD_CYCLES)) u_wr_side (
        .clk(CLK), .rst_n(RESET_N), .vs(bus.WR_VS), .en(1'b1),
        .state(wr_state), .load(wr_load)
    );

    frame_seq_side #(.LOAD_CYCLES(LOAD_CYCLES)) u_rd_side (
        .clk(CLK), .rst_n(RESET_N), .vs(bus.RD_VS), .en(frame_valid_q),
        .state(rd_state), .load(rd_load)
    );

    // A read abort (VS during RD LOAD) keeps the current buffer, so it never takes LATEST.
    assign wr_done = bus.WR_VS && (wr_state == SIDE_ACTIVE);
    assign rd_take = bus.RD_VS && frame_valid_q && fresh_q && (rd_state != SIDE_LOAD);

    always_comb begin
        wr_buf_d      = wr_buf_q;
        rd_buf_d      = rd_buf_q;
        latest_d      = latest_q;
        fresh_d       = fresh_q;
        frame_valid_d = frame_valid_q || wr_done;
        drop_cnt_d    = drop_cnt_q;
        if (wr_done && rd_take) begin
            // Reader takes the old LATEST while the just-finished frame becomes LATEST.
            rd_buf_d = latest_q;
            latest_d = wr_buf_q;
            wr_buf_d = rd_buf_q;
            fresh_d  = 1'b1;
        end else if (wr_done) begin
            wr_buf_d = latest_q;
            latest_d = wr_buf_q;
            fresh_d  = 1'b1;
            if (fresh_q && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (rd_take) begin
            rd_buf_d = latest_q;
            latest_d = rd_buf_q;
            fresh_d  = 1'b0;
        end
        wr_addr_d = buf_addr(wr_buf_d);
        wr_max_d  = wr_addr_d + FRAME_LEN;
        rd_addr_d = buf_addr(rd_buf_d);
        rd_max_d  = rd_addr_d + FRAME_LEN;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_buf_q      <= 2'd0;
            latest_q      <= 2'd1;
            rd_buf_q      <= 2'd2;
            fresh_q       <= 1'b0;
            frame_valid_q <= 1'b0;
            drop_cnt_q    <= '0;
            wr_addr_q     <= '0;
            wr_max_q      <= FRAME_LEN;
            rd_addr_q     <= RD_ADDR_RST;
            rd_max_q      <= RD_ADDR_RST + FRAME_LEN;
        end else begin
            wr_buf_q      <= wr_buf_d;
            latest_q      <= latest_d;
            rd_buf_q      <= rd_buf_d;
            fresh_q       <= fresh_d;
            frame_valid_q <= frame_valid_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_addr_q     <= wr_addr_d;
            wr_max_q      <= wr_max_d;
            rd_addr_q     <= rd_addr_d;
            rd_max_q      <= rd_max_d;
        end
    end

    assign bus.WR_ADDR     = wr_addr_q;
    assign bus.WR_MAX_ADDR = wr_max_q;
    assign bus.WR_LOAD     = wr_load;
    assign bus.RD_ADDR     = rd_addr_q;
    assign bus.RD_MAX_ADDR = rd_max_q;
    assign bus.RD_LOAD     = rd_load;
    assign bus.WR_BUF      = wr_buf_q;
    assign bus.RD_BUF      = rd_buf_q;
    assign bus.FRAME_VALID = frame_valid_q;
    assign bus.DROP_CNT    = drop_cnt_q;

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// Directed bench for frame_buffer_sequencer with default parameters.
module tb_frame_buffer_sequencer;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   errors = 0;
    int   checks = 0;

    frame_buffer_sequencer_if #(.ASIZE(23)) bus ();

    frame_buffer_sequencer #(
        .ASIZE(23), .FRAME_WORDS(307200), .BUF_STRIDE(23'h080000), .LOAD_CYCLES(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Buffer indices must always be distinct members of {0,1,2}.
    always @(negedge CLK) begin
        checks++;
        if (bus.WR_BUF > 2'd2 || bus.RD_BUF > 2'd2 || bus.WR_BUF === bus.RD_BUF) begin
            errors++;
            $display("FAIL perm_invariant: WR_BUF=%0d RD_BUF=%0d required distinct in {0,1,2}",
                     bus.WR_BUF, bus.RD_BUF);
        end
    end

    task automatic pulse(input logic w, input logic r);
        @(negedge CLK);
        bus.WR_VS = w;
        bus.RD_VS = r;
        @(negedge CLK);
        bus.WR_VS = 1'b0;
        bus.RD_VS = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        bus.WR_VS = 1'b0;
        bus.RD_VS = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.WR_BUF, bus.RD_BUF, bus.FRAME_VALID, bus.DROP_CNT, bus.WR_LOAD, bus.RD_LOAD}
            !== {2'd0, 2'd2, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: wr=%0d rd=%0d fv=%b drop=%0d wl=%b rl=%b required 0 2 0 0 0 0",
                     bus.WR_BUF, bus.RD_BUF, bus.FRAME_VALID, bus.DROP_CNT, bus.WR_LOAD, bus.RD_LOAD);
        end
        checks++;
        if ({bus.WR_ADDR, bus.WR_MAX_ADDR, bus.RD_ADDR, bus.RD_MAX_ADDR}
            !== {23'h000000, 23'h04B000, 23'h100000, 23'h14B000}) begin
            errors++;
            $display("FAIL reset_addr: %h %h %h %h required 000000 04b000 100000 14b000",
                     bus.WR_ADDR, bus.WR_MAX_ADDR, bus.RD_ADDR, bus.RD_MAX_ADDR);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_first_frame();
        repeat (9) @(negedge CLK);
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.WR_LOAD, bus.WR_ADDR, bus.WR_MAX_ADDR, bus.FRAME_VALID}
                !== {1'b1, 23'h000000, 23'h04B000, 1'b0}) begin
                errors++;
                $display("FAIL first_frame_load[%0d]: wl=%b addr=%h max=%h fv=%b required 1 000000 04b000 0",
                         i, bus.WR_LOAD, bus.WR_ADDR, bus.WR_MAX_ADDR, bus.FRAME_VALID);
            end
            @(negedge CLK);
        end
        checks++;
        if (bus.WR_LOAD !== 1'b0) begin
            errors++;
            $display("FAIL first_frame_end: WR_LOAD=%b required 0", bus.WR_LOAD);
        end
    endtask

    task automatic test_complete_and_read();
        pulse(1'b1, 1'b0);
        checks++;
        if ({bus.WR_BUF, bus.WR_ADDR, bus.WR_MAX_ADDR, bus.FRAME_VALID, bus.WR_LOAD}
            !== {2'd1, 23'h080000, 23'h0CB000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wr_complete: wr=%0d addr=%h max=%h fv=%b wl=%b required 1 080000 0cb000 1 1",
                     bus.WR_BUF, bus.WR_ADDR, bus.WR_MAX_ADDR, bus.FRAME_VALID, bus.WR_LOAD);
        end
        repeat (6) @(negedge CLK);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.RD_LOAD, bus.RD_BUF, bus.RD_ADDR, bus.RD_MAX_ADDR}
                !== {1'b1, 2'd0, 23'h000000, 23'h04B000}) begin
                errors++;
                $display("FAIL rd_take[%0d]: rl=%b rd=%0d addr=%h max=%h required 1 0 000000 04b000",
                         i, bus.RD_LOAD, bus.RD_BUF, bus.RD_ADDR, bus.RD_MAX_ADDR);
            end
            @(negedge CLK);
        end
        checks++;
        if (bus.RD_LOAD !== 1'b0) begin
            errors++;
            $display("FAIL rd_take_end: RD_LOAD=%b required 0", bus.RD_LOAD);
        end
    endtask

    task automatic test_reread();
        repeat (2) @(negedge CLK);
        pulse(1'b0, 1'b1);
        checks++;
        if ({bus.RD_LOAD, bus.RD_BUF, bus.WR_BUF} !== {1'b1, 2'd0, 2'd1}) begin
            errors++;
            $display("FAIL reread: rl=%b rd=%0d wr=%0d required 1 0 1",
                     bus.RD_LOAD, bus.RD_BUF, bus.WR_BUF);
        end
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_drop();
        for (int k = 1; k <= 300; k++) begin
            pulse(1'b1, 1'b0);
            repeat (5) @(negedge CLK);
            if (k == 3) begin
                checks++;
                if ({bus.DROP_CNT, bus.WR_BUF} !== {8'd2, 2'd2}) begin
                    errors++;
                    $display("FAIL drop_3: drop=%0d wr=%0d required 2 2", bus.DROP_CNT, bus.WR_BUF);
                end
            end
            if (k == 255 || k == 256 || k == 257) begin
                checks++;
                if (bus.DROP_CNT !== ((k == 255) ? 8'd254 : 8'd255)) begin
                    errors++;
                    $display("FAIL drop_sat_k%0d: drop=%0d required %0d", k, bus.DROP_CNT,
                             (k == 255) ? 254 : 255);
                end
            end
        end
        checks++;
        if ({bus.DROP_CNT, bus.WR_BUF, bus.RD_BUF} !== {8'd255, 2'd1, 2'd0}) begin
            errors++;
            $display("FAIL drop_300: drop=%0d wr=%0d rd=%0d required 255 1 0",
                     bus.DROP_CNT, bus.WR_BUF, bus.RD_BUF);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pulse(1'b1, 1'b0);
            repeat (5) @(negedge CLK);
        end
        checks++;
        if ({bus.WR_BUF, bus.RD_BUF, bus.DROP_CNT} !== {2'd1, 2'd2, 8'd2}) begin
            errors++;
            $display("FAIL sim_setup: wr=%0d rd=%0d drop=%0d required 1 2 2",
                     bus.WR_BUF, bus.RD_BUF, bus.DROP_CNT);
        end
        pulse(1'b1, 1'b1);
        checks++;
        if ({bus.WR_BUF, bus.RD_BUF, bus.WR_ADDR, bus.RD_ADDR, bus.RD_MAX_ADDR, bus.DROP_CNT,
             bus.WR_LOAD, bus.RD_LOAD}
            !== {2'd2, 2'd0, 23'h100000, 23'h000000, 23'h04B000, 8'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sim_fresh: wr=%0d rd=%0d wa=%h ra=%h rm=%h drop=%0d wl=%b rl=%b required 2 0 100000 000000 04b000 2 1 1",
                     bus.WR_BUF, bus.RD_BUF, bus.WR_ADDR, bus.RD_ADDR, bus.RD_MAX_ADDR,
                     bus.DROP_CNT, bus.WR_LOAD, bus.RD_LOAD);
        end
        repeat (5) @(negedge CLK);
        pulse(1'b0, 1'b1);
        checks++;
        if ({bus.RD_BUF, bus.RD_ADDR} !== {2'd1, 23'h080000}) begin
            errors++;
            $display("FAIL sim_latest_fresh: rd=%0d addr=%h required 1 080000", bus.RD_BUF, bus.RD_ADDR);
        end
        repeat (5) @(negedge CLK);
        pulse(1'b1, 1'b1);
        checks++;
        if ({bus.WR_BUF, bus.RD_BUF, bus.DROP_CNT, bus.WR_LOAD, bus.RD_LOAD}
            !== {2'd0, 2'd1, 8'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL sim_nonfresh: wr=%0d rd=%0d drop=%0d wl=%b rl=%b required 0 1 2 1 1",
                     bus.WR_BUF, bus.RD_BUF, bus.DROP_CNT, bus.WR_LOAD, bus.RD_LOAD);
        end
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_abort_and_early_read();
        do_reset();
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.RD_LOAD, bus.RD_BUF} !== {1'b0, 2'd2}) begin
                errors++;
                $display("FAIL early_read[%0d]: rl=%b rd=%0d required 0 2", i, bus.RD_LOAD, bus.RD_BUF);
            end
            @(negedge CLK);
        end
        pulse(1'b1, 1'b0);
        bus.WR_VS = 1'b1;
        @(negedge CLK);
        bus.WR_VS = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.WR_LOAD, bus.WR_BUF, bus.FRAME_VALID} !== {1'b1, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL abort_restart[%0d]: wl=%b wr=%0d fv=%b required 1 0 0",
                         i, bus.WR_LOAD, bus.WR_BUF, bus.FRAME_VALID);
            end
            @(negedge CLK);
        end
        checks++;
        if (bus.WR_LOAD !== 1'b0) begin
            errors++;
            $display("FAIL abort_end: WR_LOAD=%b required 0", bus.WR_LOAD);
        end
        pulse(1'b1, 1'b0);
        checks++;
        if ({bus.WR_BUF, bus.FRAME_VALID} !== {2'd1, 1'b1}) begin
            errors++;
            $display("FAIL after_abort_complete: wr=%0d fv=%b required 1 1", bus.WR_BUF, bus.FRAME_VALID);
        end
        repeat (5) @(negedge CLK);
    endtask

    task automatic test_async_reset();
        pulse(1'b0, 1'b1);
        checks++;
        if ({bus.RD_LOAD, bus.RD_BUF} !== {1'b1, 2'd0}) begin
            errors++;
            $display("FAIL pre_reset_rd_load: rl=%b rd=%0d required 1 0", bus.RD_LOAD, bus.RD_BUF);
        end
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if ({bus.WR_BUF, bus.RD_BUF, bus.FRAME_VALID, bus.DROP_CNT, bus.WR_LOAD, bus.RD_LOAD}
            !== {2'd0, 2'd2, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_state: wr=%0d rd=%0d fv=%b drop=%0d wl=%b rl=%b required 0 2 0 0 0 0",
                     bus.WR_BUF, bus.RD_BUF, bus.FRAME_VALID, bus.DROP_CNT, bus.WR_LOAD, bus.RD_LOAD);
        end
        checks++;
        if ({bus.WR_ADDR, bus.WR_MAX_ADDR, bus.RD_ADDR, bus.RD_MAX_ADDR}
            !== {23'h000000, 23'h04B000, 23'h100000, 23'h14B000}) begin
            errors++;
            $display("FAIL async_reset_addr: %h %h %h %h required 000000 04b000 100000 14b000",
                     bus.WR_ADDR, bus.WR_MAX_ADDR, bus.RD_ADDR, bus.RD_MAX_ADDR);
        end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.RD_LOAD, bus.WR_LOAD, bus.FRAME_VALID} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: rl=%b wl=%b fv=%b required 0 0 0",
                     bus.RD_LOAD, bus.WR_LOAD, bus.FRAME_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_complete_and_read();
        test_reread();
        test_drop();
        test_simultaneous();
        test_abort_and_early_read();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
